// File: rtl/router_fsm_nch.sv
// Router control FSM for a 1-to-N packet router. It decodes the header address,
// sequences FIFO loading for the selected channel, and drops packets that cannot be routed or that stall.
module router_fsm_nch #(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned WAIT_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] fifo_full,
  input  logic [NUM_CH-1:0] soft_reset,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy,
  output logic              drop_state,
  output logic [NUM_CH-1:0] dest_sel,
  output logic              wait_timeout
);

  localparam int unsigned      CNT_W    = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    WAIT_TILL_EMPTY    = 4'd3,
    LOAD_PARITY        = 4'd4,
    CHECK_PARITY_ERROR = 4'd5,
    FIFO_FULL_STATE    = 4'd6,
    LOAD_AFTER_FULL    = 4'd7,
    DROP_PACKET        = 4'd8
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_dest;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_wait_to;

  logic [NUM_CH-1:0] w_dest_oh;
  logic [NUM_CH-1:0] w_hdr_oh;
  logic              w_e;
  logic              w_f;
  logic              w_srst;
  logic              w_hdr_empty;
  logic              w_hdr_ok;
  logic              w_timeout;

  // Flags are qualified by masking with the one-hot channel, so no out-of-range index is ever formed.
  assign w_dest_oh   = NUM_CH'(1) << r_dest;
  assign w_hdr_oh    = NUM_CH'(1) << data_in;
  assign w_e         = |(fifo_empty & w_dest_oh);
  assign w_f         = |(fifo_full  & w_dest_oh);
  assign w_srst      = |(soft_reset & w_dest_oh);
  assign w_hdr_empty = |(fifo_empty & w_hdr_oh);
  assign w_hdr_ok    = (32'(data_in) < NUM_CH);
  assign w_timeout   = (WAIT_TIMEOUT > 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= DECODE_ADDRESS;
      r_dest    <= '0;
      r_cnt     <= '0;
      r_wait_to <= 1'b0;
    end else begin
      r_wait_to <= 1'b0;
      // Wait counter: zero on the first WAIT cycle, then counts up and saturates.
      if (r_state != WAIT_TILL_EMPTY) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_srst && (r_state != DECODE_ADDRESS) && (r_state != DROP_PACKET)) begin
        r_state <= DECODE_ADDRESS;
      end else begin
        case (r_state)
          DECODE_ADDRESS: begin
            if (pkt_valid) begin
              if (w_hdr_ok) begin
                r_dest  <= data_in;
                r_state <= w_hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
              end else begin
                r_state <= DROP_PACKET;
              end
            end
          end
          LOAD_FIRST_DATA: r_state <= LOAD_DATA;
          LOAD_DATA: begin
            if (w_f)             r_state <= FIFO_FULL_STATE;
            else if (!pkt_valid) r_state <= LOAD_PARITY;
          end
          LOAD_PARITY:        r_state <= CHECK_PARITY_ERROR;
          CHECK_PARITY_ERROR: r_state <= w_f ? FIFO_FULL_STATE : DECODE_ADDRESS;
          FIFO_FULL_STATE: begin
            if (!w_f) r_state <= LOAD_AFTER_FULL;
          end
          LOAD_AFTER_FULL: begin
            if (parity_done)        r_state <= DECODE_ADDRESS;
            else if (low_pkt_valid) r_state <= LOAD_PARITY;
            else                    r_state <= LOAD_DATA;
          end
          WAIT_TILL_EMPTY: begin
            if (w_e) begin
              r_state <= LOAD_FIRST_DATA;
            end else if (w_timeout) begin
              r_state   <= DROP_PACKET;
              r_wait_to <= 1'b1;
            end
          end
          DROP_PACKET: begin
            if (!pkt_valid) r_state <= DECODE_ADDRESS;
          end
          default: r_state <= DECODE_ADDRESS;
        endcase
      end
    end
  end

  // Moore outputs decoded straight from the state register.
  assign detect_add    = (r_state == DECODE_ADDRESS);
  assign lfd_state     = (r_state == LOAD_FIRST_DATA);
  assign ld_state      = (r_state == LOAD_DATA);
  assign laf_state     = (r_state == LOAD_AFTER_FULL);
  assign full_state    = (r_state == FIFO_FULL_STATE);
  assign rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
  assign drop_state    = (r_state == DROP_PACKET);
  assign write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                         (r_state == FIFO_FULL_STATE) || (r_state == LOAD_AFTER_FULL);
  assign busy          = (r_state != DECODE_ADDRESS);
  assign dest_sel      = ((r_state == DECODE_ADDRESS) || (r_state == DROP_PACKET)) ? '0 : w_dest_oh;
  assign wait_timeout  = r_wait_to;

endmodule

// File: tb/tb_router_fsm_nch.sv
// Directed bench for router_fsm_nch. It runs three instances: 3 channels with no timeout,
// 3 channels with a 4-cycle timeout, and 4 channels.
module tb_router_fsm_nch;

  localparam int S_DA = 0, S_LFD = 1, S_LD = 2, S_WT = 3, S_LP = 4;
  localparam int S_CPE = 5, S_FFS = 6, S_LAF = 7, S_DROP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, pkt_valid, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_empty, fifo_full, soft_reset;
  logic [3:0] fifo_empty4, fifo_full4, soft_reset4;
  logic       da[3], lfd[3], ld[3], laf[3], full[3], we[3], rir[3], busy[3], drop[3], wto[3];
  logic [2:0] ds0, ds1;
  logic [3:0] ds2;
  int checks = 0, failures = 0;

  router_fsm_nch #(.NUM_CH(3), .ADDR_W(2), .WAIT_TIMEOUT(0)) u0 (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(da[0]), .lfd_state(lfd[0]), .ld_state(ld[0]), .laf_state(laf[0]),
    .full_state(full[0]), .write_enb_reg(we[0]), .rst_int_reg(rir[0]), .busy(busy[0]),
    .drop_state(drop[0]), .dest_sel(ds0), .wait_timeout(wto[0]));

  router_fsm_nch #(.NUM_CH(3), .ADDR_W(2), .WAIT_TIMEOUT(4)) u1 (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(da[1]), .lfd_state(lfd[1]), .ld_state(ld[1]), .laf_state(laf[1]),
    .full_state(full[1]), .write_enb_reg(we[1]), .rst_int_reg(rir[1]), .busy(busy[1]),
    .drop_state(drop[1]), .dest_sel(ds1), .wait_timeout(wto[1]));

  router_fsm_nch #(.NUM_CH(4), .ADDR_W(2), .WAIT_TIMEOUT(0)) u2 (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_empty(fifo_empty4), .fifo_full(fifo_full4), .soft_reset(soft_reset4),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(da[2]), .lfd_state(lfd[2]), .ld_state(ld[2]), .laf_state(laf[2]),
    .full_state(full[2]), .write_enb_reg(we[2]), .rst_int_reg(rir[2]), .busy(busy[2]),
    .drop_state(drop[2]), .dest_sel(ds2), .wait_timeout(wto[2]));

  // Recover the state from the Moore flags. WAIT is the only busy state with no flag and no write.
  function automatic int st(input int k);
    if (da[k])   return S_DA;
    if (lfd[k])  return S_LFD;
    if (ld[k])   return S_LD;
    if (rir[k])  return S_CPE;
    if (full[k]) return S_FFS;
    if (laf[k])  return S_LAF;
    if (drop[k]) return S_DROP;
    if (we[k])   return S_LP;
    if (busy[k]) return S_WT;
    return 15;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; parity_done = 1'b0; low_pkt_valid = 1'b0;
    fifo_empty = 3'b000; fifo_full = 3'b000; soft_reset = 3'b000;
    fifo_empty4 = 4'b0000; fifo_full4 = 4'b0000; soft_reset4 = 4'b0000;
    step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    resetn = 1'b0; pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b111; fifo_empty4 = 4'b1111;
    step();
    if (st(0) !== S_DA) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", st(0), S_DA); end
    checks++;
    if (busy[0] !== 1'b0 || we[0] !== 1'b0 || wto[0] !== 1'b0) begin
      failures++; $display("FAIL reset_outputs busy=%b we=%b wto=%b exp=000", busy[0], we[0], wto[0]);
    end
    checks++;
    if (ds0 !== 3'b000) begin failures++; $display("FAIL reset_dest_sel got=%b exp=000", ds0); end
    checks++;
    if (st(2) !== S_DA) begin failures++; $display("FAIL reset_state_nch4 got=%0d exp=%0d", st(2), S_DA); end
    checks++;
    resetn = 1'b1; pkt_valid = 1'b0;
  endtask

  task automatic test_normal();
    int pv[8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    int ex[8] = '{S_LFD, S_LD, S_LD, S_LD, S_LD, S_LP, S_CPE, S_DA};
    int nwe = 0;
    logic [2:0] eds;
    do_reset();
    data_in = 2'd2; fifo_empty = 3'b100;
    for (int i = 0; i < 8; i++) begin
      pkt_valid = 1'(pv[i]);
      step();
      if (st(0) !== ex[i]) begin failures++; $display("FAIL normal_state cyc=%0d got=%0d exp=%0d", i, st(0), ex[i]); end
      checks++;
      eds = (ex[i] == S_DA) ? 3'b000 : 3'b100;
      if (ds0 !== eds) begin failures++; $display("FAIL normal_dest_sel cyc=%0d got=%b exp=%b", i, ds0, eds); end
      checks++;
      if (we[0] === 1'b1) nwe++;
    end
    if (nwe !== 5) begin failures++; $display("FAIL normal_we_count got=%0d exp=5", nwe); end
    checks++;
  endtask

  task automatic test_wait();
    int pv[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [2:0] fe[8] = '{3'b101, 3'b101, 3'b101, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
    int ex[8] = '{S_WT, S_WT, S_WT, S_LFD, S_LD, S_LP, S_CPE, S_DA};
    do_reset();
    data_in = 2'd1;
    for (int i = 0; i < 8; i++) begin
      pkt_valid = 1'(pv[i]); fifo_empty = fe[i];
      step();
      if (st(0) !== ex[i]) begin failures++; $display("FAIL wait_state cyc=%0d got=%0d exp=%0d", i, st(0), ex[i]); end
      checks++;
      if (i < 3 && (we[0] !== 1'b0 || ds0 !== 3'b010)) begin
        failures++; $display("FAIL wait_outputs cyc=%0d we=%b ds=%b exp we=0 ds=010", i, we[0], ds0);
      end
      if (i < 3) checks++;
    end
  endtask

  task automatic test_drop();
    do_reset();
    data_in = 2'd3; pkt_valid = 1'b1; fifo_empty = 3'b111;
    for (int i = 0; i < 5; i++) begin
      step();
      if (st(0) !== S_DROP) begin failures++; $display("FAIL drop_state cyc=%0d got=%0d exp=%0d", i, st(0), S_DROP); end
      checks++;
      if (wto[0] !== 1'b0 || we[0] !== 1'b0 || ds0 !== 3'b000) begin
        failures++; $display("FAIL drop_outputs cyc=%0d wto=%b we=%b ds=%b exp 0 0 000", i, wto[0], we[0], ds0);
      end
      checks++;
      soft_reset = 3'b111;
      if (i == 4) begin pkt_valid = 1'b0; soft_reset = 3'b000; end
    end
    step();
    if (st(0) !== S_DA) begin failures++; $display("FAIL drop_exit got=%0d exp=%0d", st(0), S_DA); end
    checks++;
  endtask

  task automatic test_timeout();
    int ex;
    do_reset();
    data_in = 2'd0; pkt_valid = 1'b1; fifo_empty = 3'b000;
    for (int i = 0; i < 6; i++) begin
      step();
      ex = (i < 4) ? S_WT : S_DROP;
      if (st(1) !== ex) begin failures++; $display("FAIL timeout_state cyc=%0d got=%0d exp=%0d", i, st(1), ex); end
      checks++;
      if (wto[1] !== 1'(i == 4)) begin failures++; $display("FAIL timeout_pulse cyc=%0d got=%b exp=%b", i, wto[1], 1'(i == 4)); end
      checks++;
    end
    pkt_valid = 1'b0;
    step();
    if (st(1) !== S_DA) begin failures++; $display("FAIL timeout_drop_exit got=%0d exp=%0d", st(1), S_DA); end
    checks++;
    if (st(0) !== S_WT) begin failures++; $display("FAIL no_timeout_wait got=%0d exp=%0d", st(0), S_WT); end
    checks++;

    do_reset();
    data_in = 2'd0; pkt_valid = 1'b1; fifo_empty = 3'b000;
    for (int i = 0; i < 4; i++) step();
    fifo_empty = 3'b001;
    step();
    if (st(1) !== S_LFD || wto[1] !== 1'b0) begin
      failures++; $display("FAIL timeout_empty_priority state=%0d wto=%b exp state=%0d wto=0", st(1), wto[1], S_LFD);
    end
    checks++;
    pkt_valid = 1'b0;
    step();
    if (st(1) !== S_LD || wto[1] !== 1'b0) begin
      failures++; $display("FAIL timeout_after_lfd state=%0d wto=%b exp state=%0d wto=0", st(1), wto[1], S_LD);
    end
    checks++;
  endtask

  task automatic test_full();
    logic [2:0] ff[11] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000};
    int pd[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    int lp[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    int ex[11] = '{S_LFD, S_LD, S_LD, S_FFS, S_FFS, S_LAF, S_LP, S_CPE, S_FFS, S_LAF, S_DA};
    logic ewe;
    do_reset();
    data_in = 2'd1; pkt_valid = 1'b1; fifo_empty = 3'b010;
    for (int i = 0; i < 11; i++) begin
      fifo_full = ff[i]; parity_done = 1'(pd[i]); low_pkt_valid = 1'(lp[i]);
      step();
      if (st(0) !== ex[i]) begin failures++; $display("FAIL full_state cyc=%0d got=%0d exp=%0d", i, st(0), ex[i]); end
      checks++;
      ewe = 1'(ex[i] == S_LD || ex[i] == S_LP || ex[i] == S_FFS || ex[i] == S_LAF);
      if (we[0] !== ewe) begin failures++; $display("FAIL full_we cyc=%0d got=%b exp=%b", i, we[0], ewe); end
      checks++;
    end
    parity_done = 1'b0; low_pkt_valid = 1'b0; fifo_full = 3'b000;
  endtask

  task automatic test_soft_reset();
    logic [2:0] sr[6] = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b010, 3'b010};
    int ex[6] = '{S_LFD, S_LD, S_LD, S_DA, S_LFD, S_DA};
    do_reset();
    data_in = 2'd1; pkt_valid = 1'b1; fifo_empty = 3'b010;
    for (int i = 0; i < 6; i++) begin
      soft_reset = sr[i];
      step();
      if (st(0) !== ex[i]) begin failures++; $display("FAIL soft_reset_state cyc=%0d got=%0d exp=%0d", i, st(0), ex[i]); end
      checks++;
    end
    if (ds0 !== 3'b000) begin failures++; $display("FAIL soft_reset_dest_sel got=%b exp=000", ds0); end
    checks++;
    soft_reset = 3'b000;
    step();
    step();
    fifo_full = 3'b010;
    step();
    if (st(0) !== S_FFS) begin failures++; $display("FAIL hard_reset_setup got=%0d exp=%0d", st(0), S_FFS); end
    checks++;
    resetn = 1'b0;
    step();
    if (st(0) !== S_DA || ds0 !== 3'b000 || busy[0] !== 1'b0) begin
      failures++; $display("FAIL hard_reset_in_ffs state=%0d ds=%b busy=%b exp state=%0d ds=000 busy=0", st(0), ds0, busy[0], S_DA);
    end
    checks++;
    resetn = 1'b1; fifo_full = 3'b000; pkt_valid = 1'b0;
  endtask

  task automatic test_nch4();
    int pv[5] = '{1, 1, 0, 0, 0};
    int ex[5] = '{S_LFD, S_LD, S_LP, S_CPE, S_DA};
    logic [3:0] eds;
    do_reset();
    data_in = 2'd3; fifo_empty4 = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      pkt_valid = 1'(pv[i]);
      step();
      if (st(2) !== ex[i]) begin failures++; $display("FAIL nch4_state cyc=%0d got=%0d exp=%0d", i, st(2), ex[i]); end
      checks++;
      eds = (ex[i] == S_DA) ? 4'b0000 : 4'b1000;
      if (ds2 !== eds) begin failures++; $display("FAIL nch4_dest_sel cyc=%0d got=%b exp=%b", i, ds2, eds); end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_wait();
    test_drop();
    test_timeout();
    test_full();
    test_soft_reset();
    test_nch4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
